// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator result monitor.
// - FSM state encoding for the equal-run tracker
// - one-hot result vector constants, ordered {lt, eq, gt}
// - is_legal(): true when exactly one comparator output is high
package cmp_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TRACK_EQ = 2'd1;
  localparam logic [1:0] ST_MATCHED  = 2'd2;

  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

  function automatic logic is_legal(input logic [2:0] res);
    return (res == RES_LT) || (res == RES_EQ) || (res == RES_GT);
  endfunction

endpackage

// File: rtl/cmp_result_monitor_if.sv
// Sample bus from the magnitude comparator into the result monitor.
// Signals:
//   sample_valid - strobe; lt/eq/gt are meaningful when high
//   lt, eq, gt   - comparator outputs a<b, a==b, a>b
// Modports: master drives the sample, slave (the monitor) receives it.
interface cmp_result_monitor_if;
  logic sample_valid;
  logic lt;
  logic eq;
  logic gt;

  modport master (output sample_valid, output lt, output eq, output gt);
  modport slave  (input  sample_valid, input  lt, input  eq, input  gt);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear, wins over inc
//   inc        - count enable
//   q          - count value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cmp_result_monitor.sv
// Monitors the 4-bit comparator's lt/eq/gt outputs.
// Keeps saturating counts per legal outcome and of illegal (non-one-hot)
// vectors, a sticky error flag, the last sampled vector, and an FSM that
// asserts match after MATCH_RUN consecutive legal eq samples.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clr          - synchronous clear of everything; drops a coincident sample
//   bus          - sample strobe and comparator outputs (slave modport)
//   lt/eq/gt_cnt - counts of legal samples per outcome
//   err_cnt, err - count of illegal samples, sticky illegal flag
//   last_res     - {lt,eq,gt} of the most recent sample
//   run_len      - current consecutive-eq run, saturating
//   match        - FSM is in MATCHED
//   match_pulse  - one cycle after entering MATCHED
module cmp_result_monitor
  import cmp_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MATCH_RUN = 3,
  parameter int RUN_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  cmp_result_monitor_if.slave  bus,
  output logic [CNT_W-1:0]     lt_cnt,
  output logic [CNT_W-1:0]     eq_cnt,
  output logic [CNT_W-1:0]     gt_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err,
  output logic [2:0]           last_res,
  output logic [RUN_W-1:0]     run_len,
  output logic                 match,
  output logic                 match_pulse
);

  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(MATCH_RUN);
  localparam logic [RUN_W-1:0] RUN_MAX    = {RUN_W{1'b1}};

  logic [2:0] res;
  logic       legal;
  logic       legal_eq;

  assign res      = {bus.lt, bus.eq, bus.gt};
  assign legal    = is_legal(res);
  assign legal_eq = (res == RES_EQ);

  // Counter index: 0=lt, 1=eq, 2=gt, 3=err
  logic [3:0]       inc_vec;
  logic [CNT_W-1:0] cnt_arr [4];

  assign inc_vec[0] = bus.sample_valid && (res == RES_LT);
  assign inc_vec[1] = bus.sample_valid && legal_eq;
  assign inc_vec[2] = bus.sample_valid && (res == RES_GT);
  assign inc_vec[3] = bus.sample_valid && !legal;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_vec[gi]),
        .q     (cnt_arr[gi])
      );
    end
  endgenerate

  assign lt_cnt  = cnt_arr[0];
  assign eq_cnt  = cnt_arr[1];
  assign gt_cnt  = cnt_arr[2];
  assign err_cnt = cnt_arr[3];

  logic [1:0]       state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic             pulse_next;
  logic             err_reg;
  logic [2:0]       last_res_reg;
  logic             match_reg;
  logic             pulse_reg;

  // Any sample other than a legal eq (lt, gt or illegal) breaks the run.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    pulse_next = 1'b0;
    if (bus.sample_valid) begin
      if (!legal_eq) begin
        state_next = ST_IDLE;
        run_next   = '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            run_next = RUN_W'(1);
            if (RUN_TARGET == RUN_W'(1)) begin
              state_next = ST_MATCHED;
              pulse_next = 1'b1;
            end else begin
              state_next = ST_TRACK_EQ;
            end
          end
          ST_TRACK_EQ: begin
            // Run is below MATCH_RUN here, so the increment cannot overflow.
            run_next = run_reg + RUN_W'(1);
            if (run_next == RUN_TARGET) begin
              state_next = ST_MATCHED;
              pulse_next = 1'b1;
            end
          end
          ST_MATCHED: begin
            if (run_reg != RUN_MAX) run_next = run_reg + RUN_W'(1);
          end
          default: begin
            state_next = ST_IDLE;
            run_next   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      run_reg      <= '0;
      err_reg      <= 1'b0;
      last_res_reg <= 3'b000;
      match_reg    <= 1'b0;
      pulse_reg    <= 1'b0;
    end else if (clr) begin
      state_reg    <= ST_IDLE;
      run_reg      <= '0;
      err_reg      <= 1'b0;
      last_res_reg <= 3'b000;
      match_reg    <= 1'b0;
      pulse_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      match_reg <= (state_next == ST_MATCHED);
      pulse_reg <= pulse_next;
      if (bus.sample_valid) begin
        last_res_reg <= res;
        if (!legal) err_reg <= 1'b1;
      end
    end
  end

  assign err         = err_reg;
  assign last_res    = last_res_reg;
  assign run_len     = run_reg;
  assign match       = match_reg;
  assign match_pulse = pulse_reg;

endmodule
